instr_fetch: RTL and testbench
==============================

# instr_fetch

Instruction fetch sequencer that sits upstream of the control decoder. It walks the program counter through a synchronous-read instruction memory and presents each 9-bit machine word to the decoder. It consumes the decoder's branch decision (`branch`, `how_high`) and redirects fetch through a 4-entry branch-target lookup table. It runs from a `start` pulse to a halt word and then raises `done`.

## Interface
- `PC_W`, 10, program counter / instruction memory address width
- `MCODE_W`, 9, machine word width
- `HALT_INSTR`, 9'h1FF, encoding that ends execution
- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately
- `start`  in  1  begin execution at PC 0; sampled in IDLE or DONE only
- `done`  out  1  program halted; held until next accepted `start`
- `imem_addr`  out  PC_W  fetch address; registered
- `imem_rdata`  in  MCODE_W  word at the address presented in the previous cycle
- `instr`  out  MCODE_W  word to the decoder; equals `imem_rdata`
- `instr_valid`  out  1  `instr` is architecturally live; downstream gates all writes with it
- `pc`  out  PC_W  address of the word currently on `instr`
- `branch`  in  1  decoder branch (already zero-qualified); honoured only when `instr_valid`=1
- `how_high`  in  2  LUT index for the branch target
- `lut_we`  in  1  write the branch-target LUT
- `lut_idx`  in  2  LUT write index
- `lut_data`  in  PC_W  absolute target address

## Operation
- Registers:
  - `fetch_pc` drives `imem_addr`.
  - `dec_pc` drives `pc`.
  - `dec_valid`.
  - Four LUT entries.
- States:
  - IDLE: `start`=1 → FILL, `fetch_pc`←0.
  - FILL: one cycle → RUN, `dec_pc`←0, `dec_valid`←1, `fetch_pc`←1.
  - RUN: runs until halt.
  - DONE: `done`=1; `start`=1 → FILL, `fetch_pc`←0.
- `instr_valid` = `dec_valid` AND state==RUN AND `instr`≠`HALT_INSTR`. The halt word is never presented as valid.
- RUN sequential, no taken branch: `dec_pc`←`fetch_pc`, `dec_valid`←1, `fetch_pc`←`fetch_pc`+1.
- RUN taken branch (`instr_valid` AND `branch`):
  - Updates: `fetch_pc`←LUT[`how_high`], `dec_valid`←0, `dec_pc` holds.
  - Bubble cycle: the next cycle's word is wrong-path and is squashed.
  - Following edge: resumes the sequential rule, so the target appears valid 2 cycles after the branch.
- RUN halt (`dec_valid` AND `instr`==`HALT_INSTR`): → DONE; `dec_valid`←0.
- `start` during FILL or RUN is ignored.
- LUT:
  - A write is accepted in any state.
  - Same-cycle write and branch read of the same index returns the old value.
- PC arithmetic is modulo 2^PC_W: `fetch_pc` at all-ones wraps to 0 with no error.
- `branch` while `instr_valid`=0 (bubble, halt, FILL, IDLE, DONE) is ignored.

## Timing
- Reset values:
  - State IDLE.
  - `fetch_pc`, `dec_pc` and all LUT entries 0.
  - `dec_valid` 0.
  - Outputs: `imem_addr`=0, `pc`=0, `instr_valid`=0, `done`=0. `instr` follows `imem_rdata`, qualified invalid.
- Reset mid-operation:
  - Same values as above, applied asynchronously.
  - Any in-flight branch is discarded.
  - LUT contents are lost.
- `start` sampled in cycle 0 → FILL in cycle 1 → first valid `instr` (PC 0) in cycle 2.
- Sequential throughput: one valid word per cycle.
- Taken-branch penalty: exactly 1 bubble cycle.
- Not-taken branch: 0 bubbles.
- Halt at cycle t (`instr_valid`=0) → `done`=1 from cycle t+1.

## Structure
- Shared package `fetch_pkg`:
  - State enum IDLE/FILL/RUN/DONE.
  - `PC_W` and `MCODE_W` defaults.
  - `HALT_INSTR` default.
  - LUT depth constant (4).
- Sub-module `branch_lut`:
  - 4×PC_W register file.
  - Async active-low clear.
  - One write port, one combinational read port.

## Test plan
- Straight line: mem[0..3]=9'h000, mem[4]=HALT, start in cycle 0 → `instr_valid`=1 in cycles 2–5 with `pc`=0..3; cycle 6 `instr_valid`=0; `done`=1 from cycle 7.
- Taken branch: LUT[2]=20, mem[5] decoded with `branch`=1, `how_high`=2 → one bubble cycle, PC 6 never valid, next valid `pc`=20, then 21.
- Not-taken: same program with `branch`=0 at PC 5 → `pc`=6 valid in the very next cycle, no bubble.
- LUT hazard: `lut_we`=1, `lut_idx`=1, `lut_data`=40 in the same cycle as a taken branch with `how_high`=1 and old LUT[1]=30 → target 30; a later branch with `how_high`=1 → target 40.
- Reset mid-RUN at `pc`=7 → `instr_valid`, `done`, `imem_addr` and `pc` go to 0 without a clock edge, and LUT reads 0. A fresh `start` refetches from PC 0.
- Wrap and restart:
  - PC_W=4 with no halt → valid `pc` sequence 14, 15, 0, 1.
  - After a halt, `start` in DONE → `done` drops and PC 0 is valid two cycles later.

Source files
------------

// File: rtl/fetch_pkg.sv
// ---------------------------------------------------------------------------
// fetch_pkg : shared types and defaults for the instruction fetch sequencer
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int DEF_PC_W    = 10;
    localparam int DEF_MCODE_W = 9;
    localparam logic [DEF_MCODE_W-1:0] DEF_HALT_INSTR = 9'h1FF;

    localparam int LUT_DEPTH = 4;
    localparam int LUT_IDX_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if : control, imem, decoder and LUT-write signals of the fetcher
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_if
    import fetch_pkg::*;
#(
    parameter int PC_W    = DEF_PC_W,
    parameter int MCODE_W = DEF_MCODE_W
);

    logic                 start;
    logic                 done;
    logic [PC_W-1:0]      imem_addr;
    logic [MCODE_W-1:0]   imem_rdata;
    logic [MCODE_W-1:0]   instr;
    logic                 instr_valid;
    logic [PC_W-1:0]      pc;
    logic                 branch;
    logic [LUT_IDX_W-1:0] how_high;
    logic                 lut_we;
    logic [LUT_IDX_W-1:0] lut_idx;
    logic [PC_W-1:0]      lut_data;

    // master: the fetch sequencer; slave: memory, decoder and controller
    modport master (
        input  start, imem_rdata, branch, how_high, lut_we, lut_idx, lut_data,
        output done, imem_addr, instr, instr_valid, pc
    );

    modport slave (
        output start, imem_rdata, branch, how_high, lut_we, lut_idx, lut_data,
        input  done, imem_addr, instr, instr_valid, pc
    );

endinterface

`default_nettype wire

// File: rtl/branch_lut.sv
// ---------------------------------------------------------------------------
// branch_lut : 4-entry branch-target register file, 1 write / 1 comb read
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module branch_lut
    import fetch_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    input  wire logic                 we_i,
    input  wire logic [LUT_IDX_W-1:0] widx_i,
    input  wire logic [PC_W-1:0]      wdata_i,
    input  wire logic [LUT_IDX_W-1:0] ridx_i,
    output logic      [PC_W-1:0]      rdata_o
);

    logic [PC_W-1:0] entry_q [LUT_DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else if (we_i) begin
            entry_q[widx_i] <= wdata_i;
        end
    end

    // Read sees the registered contents, so a same-cycle write is not visible
    assign rdata_o = entry_q[ridx_i];

endmodule

`default_nettype wire

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch : PC sequencer over a sync-read imem with LUT-redirected branches
// Revision    : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module instr_fetch
    import fetch_pkg::*;
#(
    parameter int                 PC_W       = DEF_PC_W,
    parameter int                 MCODE_W    = DEF_MCODE_W,
    parameter logic [MCODE_W-1:0] HALT_INSTR = MCODE_W'(DEF_HALT_INSTR)
) (
    input  wire logic   clk,
    input  wire logic   reset,
    instr_fetch_if.master bus
);

    state_t          state_q;
    logic [PC_W-1:0] fetch_pc_q;
    logic [PC_W-1:0] fetch_pc_d;
    logic [PC_W-1:0] dec_pc_q;
    logic            dec_valid_q;
    logic            done_q;

    logic [PC_W-1:0] lut_target;
    logic            is_halt_word;
    logic            instr_valid;
    logic            taken;
    logic            halt;

    branch_lut #(
        .PC_W (PC_W)
    ) u_branch_lut (
        .clk     (clk),
        .reset   (reset),
        .we_i    (bus.lut_we),
        .widx_i  (bus.lut_idx),
        .wdata_i (bus.lut_data),
        .ridx_i  (bus.how_high),
        .rdata_o (lut_target)
    );

    assign is_halt_word = (bus.imem_rdata == HALT_INSTR);
    assign instr_valid  = dec_valid_q && (state_q == ST_RUN) && !is_halt_word;
    assign taken        = instr_valid && bus.branch;
    assign halt         = dec_valid_q && (state_q == ST_RUN) && is_halt_word;
    assign fetch_pc_d   = fetch_pc_q + PC_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= '0;
            dec_pc_q    <= '0;
            dec_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q    <= ST_FILL;
                        fetch_pc_q <= '0;
                    end
                end
                ST_FILL: begin
                    state_q     <= ST_RUN;
                    dec_pc_q    <= '0;
                    dec_valid_q <= 1'b1;
                    fetch_pc_q  <= PC_W'(1);
                end
                ST_RUN: begin
                    if (halt) begin
                        state_q     <= ST_DONE;
                        dec_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else if (taken) begin
                        // Word already in flight is wrong-path; squash it
                        fetch_pc_q  <= lut_target;
                        dec_valid_q <= 1'b0;
                    end else begin
                        dec_pc_q    <= fetch_pc_q;
                        dec_valid_q <= 1'b1;
                        fetch_pc_q  <= fetch_pc_d;
                    end
                end
                ST_DONE: begin
                    if (bus.start) begin
                        state_q    <= ST_FILL;
                        fetch_pc_q <= '0;
                        done_q     <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.imem_addr   = fetch_pc_q;
    assign bus.pc          = dec_pc_q;
    assign bus.instr       = bus.imem_rdata;
    assign bus.instr_valid = instr_valid;
    assign bus.done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch : directed scenarios for instr_fetch (PC_W=10 and PC_W=4)
// Revision       : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;
    import fetch_pkg::*;

    localparam logic [8:0] HALT = 9'h1FF;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_if #(.PC_W(10), .MCODE_W(9)) ifa ();
    instr_fetch_if #(.PC_W(4),  .MCODE_W(9)) ifb ();

    instr_fetch #(.PC_W(10), .MCODE_W(9), .HALT_INSTR(HALT)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa.master)
    );

    instr_fetch #(.PC_W(4), .MCODE_W(9), .HALT_INSTR(HALT)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb.master)
    );

    logic [8:0] mem_a [0:1023];
    logic [8:0] mem_b [0:15];

    always @(posedge clk) begin
        ifa.imem_rdata <= mem_a[ifa.imem_addr];
        ifb.imem_rdata <= mem_b[ifb.imem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        ifa.start = 1'b1;
        step();
        ifa.start = 1'b0;
    endtask

    task automatic run_to_pc(input logic [9:0] target);
        for (int i = 0; i < 200; i++) begin
            if (ifa.instr_valid === 1'b1 && ifa.pc === target) break;
            step();
        end
    endtask

    task automatic run_to_done();
        for (int i = 0; i < 200; i++) begin
            if (ifa.done === 1'b1) break;
            step();
        end
    endtask

    task automatic test_reset();
        ifa.start = 0; ifa.branch = 0; ifa.how_high = 0;
        ifa.lut_we = 0; ifa.lut_idx = 0; ifa.lut_data = 0;
        ifb.start = 0; ifb.branch = 0; ifb.how_high = 0;
        ifb.lut_we = 0; ifb.lut_idx = 0; ifb.lut_data = 0;
        for (int i = 0; i < 1024; i++) mem_a[i] = 9'h000;
        for (int i = 0; i < 16; i++) mem_b[i] = 9'h000;
        reset = 1'b0;
        step();
        step();
        checks++; if (ifa.imem_addr !== 10'd0) begin errors++; $display("FAIL reset_imem_addr got %0d want 0", ifa.imem_addr); end
        checks++; if (ifa.pc !== 10'd0) begin errors++; $display("FAIL reset_pc got %0d want 0", ifa.pc); end
        checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ifa.instr_valid); end
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", ifa.done); end
        reset = 1'b1;
        step();
        checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", ifa.instr_valid); end
    endtask

    task automatic test_straight_line();
        mem_a[4] = HALT;
        pulse_start();
        checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL fill_valid got %b want 0", ifa.instr_valid); end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'(k)) begin
                errors++; $display("FAIL straight_pc%0d got valid=%b pc=%0d want valid=1 pc=%0d", k, ifa.instr_valid, ifa.pc, k);
            end
        end
        step();
        checks++; if (ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL halt_valid got %b want 0", ifa.instr_valid); end
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL halt_done_early got %b want 0", ifa.done); end
        step();
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL done_set got %b want 1", ifa.done); end
        step();
        checks++; if (ifa.done !== 1'b1 || ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL done_hold got done=%b valid=%b want 1 0", ifa.done, ifa.instr_valid); end
    endtask

    task automatic test_taken_branch();
        mem_a[4]  = 9'h000;
        mem_a[6]  = 9'h0AB;
        mem_a[22] = HALT;
        mem_a[42] = HALT;
        ifa.lut_we = 1; ifa.lut_idx = 2; ifa.lut_data = 10'd20;
        step();
        ifa.lut_we = 0;
        pulse_start();
        checks++; if (ifa.done !== 1'b0) begin errors++; $display("FAIL restart_done got %b want 0", ifa.done); end
        run_to_pc(10'd5);
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd5) begin errors++; $display("FAIL br_reach5 got pc=%0d want 5", ifa.pc); end
        ifa.branch = 1; ifa.how_high = 2;
        step();
        ifa.branch = 0; ifa.how_high = 0;
        checks++; if (ifa.instr_valid !== 1'b0 || ifa.imem_addr !== 10'd20) begin errors++; $display("FAIL br_bubble got valid=%b addr=%0d want 0 20", ifa.instr_valid, ifa.imem_addr); end
        step();
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd20) begin errors++; $display("FAIL br_target got valid=%b pc=%0d want 1 20", ifa.instr_valid, ifa.pc); end
        step();
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd21) begin errors++; $display("FAIL br_next got valid=%b pc=%0d want 1 21", ifa.instr_valid, ifa.pc); end
        run_to_done();
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL br_done got %b want 1", ifa.done); end
    endtask

    task automatic test_not_taken();
        pulse_start();
        run_to_pc(10'd5);
        ifa.branch = 0; ifa.how_high = 2;
        step();
        ifa.how_high = 0;
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd6 || ifa.instr !== 9'h0AB) begin
            errors++; $display("FAIL nt_pc6 got valid=%b pc=%0d instr=%h want 1 6 0ab", ifa.instr_valid, ifa.pc, ifa.instr);
        end
        run_to_done();
        checks++; if (ifa.done !== 1'b1 || ifa.pc !== 10'd22) begin errors++; $display("FAIL nt_done got done=%b pc=%0d want 1 22", ifa.done, ifa.pc); end
    endtask

    task automatic test_lut_hazard();
        ifa.lut_we = 1; ifa.lut_idx = 1; ifa.lut_data = 10'd30;
        step();
        ifa.lut_we = 0;
        pulse_start();
        run_to_pc(10'd5);
        ifa.branch = 1; ifa.how_high = 1;
        ifa.lut_we = 1; ifa.lut_idx = 1; ifa.lut_data = 10'd40;
        step();
        ifa.branch = 0; ifa.how_high = 0; ifa.lut_we = 0;
        checks++; if (ifa.imem_addr !== 10'd30) begin errors++; $display("FAIL hazard_old got addr=%0d want 30", ifa.imem_addr); end
        step();
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd30) begin errors++; $display("FAIL hazard_pc30 got valid=%b pc=%0d want 1 30", ifa.instr_valid, ifa.pc); end
        step();
        ifa.branch = 1; ifa.how_high = 1;
        step();
        ifa.branch = 0; ifa.how_high = 0;
        checks++; if (ifa.imem_addr !== 10'd40 || ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL hazard_new got addr=%0d valid=%b want 40 0", ifa.imem_addr, ifa.instr_valid); end
        step();
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd40) begin errors++; $display("FAIL hazard_pc40 got valid=%b pc=%0d want 1 40", ifa.instr_valid, ifa.pc); end
        run_to_done();
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL hazard_done got %b want 1", ifa.done); end
    endtask

    task automatic test_reset_mid_run();
        pulse_start();
        run_to_pc(10'd7);
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd7) begin errors++; $display("FAIL mid_reach7 got pc=%0d want 7", ifa.pc); end
        #2 reset = 1'b0;
        #1;
        checks++; if (ifa.imem_addr !== 10'd0 || ifa.pc !== 10'd0) begin errors++; $display("FAIL mid_async_pc got addr=%0d pc=%0d want 0 0", ifa.imem_addr, ifa.pc); end
        checks++; if (ifa.instr_valid !== 1'b0 || ifa.done !== 1'b0) begin errors++; $display("FAIL mid_async_flags got valid=%b done=%b want 0 0", ifa.instr_valid, ifa.done); end
        step();
        reset = 1'b1;
        pulse_start();
        step();
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd0) begin errors++; $display("FAIL mid_refetch got valid=%b pc=%0d want 1 0", ifa.instr_valid, ifa.pc); end
        run_to_pc(10'd5);
        ifa.branch = 1; ifa.how_high = 2;
        step();
        ifa.branch = 0; ifa.how_high = 0;
        checks++; if (ifa.imem_addr !== 10'd0) begin errors++; $display("FAIL mid_lut_cleared got addr=%0d want 0", ifa.imem_addr); end
        step();
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd0) begin errors++; $display("FAIL mid_lut_target got valid=%b pc=%0d want 1 0", ifa.instr_valid, ifa.pc); end
        run_to_done();
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL mid_done got %b want 1", ifa.done); end
    endtask

    task automatic test_restart();
        ifa.lut_we = 1; ifa.lut_idx = 3; ifa.lut_data = 10'd9;
        step();
        ifa.lut_we = 0;
        ifa.branch = 1; ifa.how_high = 3;
        pulse_start();
        checks++; if (ifa.done !== 1'b0 || ifa.instr_valid !== 1'b0) begin errors++; $display("FAIL restart_fill got done=%b valid=%b want 0 0", ifa.done, ifa.instr_valid); end
        ifa.branch = 0; ifa.how_high = 0;
        step();
        checks++; if (ifa.instr_valid !== 1'b1 || ifa.pc !== 10'd0 || ifa.imem_addr !== 10'd1) begin
            errors++; $display("FAIL restart_pc0 got valid=%b pc=%0d addr=%0d want 1 0 1", ifa.instr_valid, ifa.pc, ifa.imem_addr);
        end
        run_to_done();
        checks++; if (ifa.done !== 1'b1) begin errors++; $display("FAIL restart_done got %b want 1", ifa.done); end
    endtask

    task automatic test_wrap();
        ifb.start = 1'b1;
        step();
        ifb.start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (ifb.instr_valid === 1'b1 && ifb.pc === 4'd14) break;
            step();
        end
        checks++; if (ifb.instr_valid !== 1'b1 || ifb.pc !== 4'd14) begin errors++; $display("FAIL wrap_pc14 got valid=%b pc=%0d want 1 14", ifb.instr_valid, ifb.pc); end
        step();
        checks++; if (ifb.instr_valid !== 1'b1 || ifb.pc !== 4'd15) begin errors++; $display("FAIL wrap_pc15 got valid=%b pc=%0d want 1 15", ifb.instr_valid, ifb.pc); end
        step();
        checks++; if (ifb.instr_valid !== 1'b1 || ifb.pc !== 4'd0) begin errors++; $display("FAIL wrap_pc0 got valid=%b pc=%0d want 1 0", ifb.instr_valid, ifb.pc); end
        step();
        checks++; if (ifb.instr_valid !== 1'b1 || ifb.pc !== 4'd1) begin errors++; $display("FAIL wrap_pc1 got valid=%b pc=%0d want 1 1", ifb.instr_valid, ifb.pc); end
    endtask

    initial begin
        test_reset();
        test_straight_line();
        test_taken_branch();
        test_not_taken();
        test_lut_hazard();
        test_reset_mid_run();
        test_restart();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

endmodule

`default_nettype wire
